// File: rtl/gl3456_out_fifo_if.sv
// rtl/gl3456_out_fifo_if.sv - upstream/downstream stream bundle for the output FIFO
// The FIFO takes the slave view; the producer/consumer side takes the master view.
interface gl3456_out_fifo_if #(
  parameter int D_WIDTH = 8
);
  logic [D_WIDTH-1:0] up_data;
  logic               up_valid;
  logic               up_tlast;
  logic               up_tuser;
  logic               up_ready;
  logic [D_WIDTH-1:0] down_data;
  logic               down_valid;
  logic               down_tlast;
  logic               down_tuser;
  logic               down_ready;

  modport slave (
    input  up_data, up_valid, up_tlast, up_tuser, down_ready,
    output up_ready, down_data, down_valid, down_tlast, down_tuser
  );

  modport master (
    output up_data, up_valid, up_tlast, up_tuser, down_ready,
    input  up_ready, down_data, down_valid, down_tlast, down_tuser
  );
endinterface

// File: rtl/gl3456_out_fifo.sv
// rtl/gl3456_out_fifo.sv - show-ahead stream FIFO after the 2x2 decimation queue
// Define GL3456_FRAME_DROP_EN to drop on overflow and resync on start-of-frame.
module gl3456_out_fifo #(
  parameter int D_WIDTH    = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  gl3456_out_fifo_if.slave      bus,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic                  frame_dropped
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DEPTH_LOG2:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2:0] rptr_q, rptr_d;
  logic [D_WIDTH+1:0]  mem_q [DEPTH];
  logic [D_WIDTH+1:0]  head;
  logic                empty;
  logic                full;
  logic                accept;
  logic                push;
  logic                pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                 (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);

`ifdef GL3456_FRAME_DROP_EN
  typedef enum logic {ST_PASS, ST_DROP} state_t;
  state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_PASS;
    else      state_q <= state_d;
  end

  // Overflow never back-pressures: the beat is lost and we wait for the next SOF.
  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    frame_dropped = 1'b0;
    case (state_q)
      ST_PASS: begin
        if (bus.up_valid) begin
          if (full) begin
            state_d       = ST_DROP;
            frame_dropped = 1'b1;
          end else begin
            accept = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (bus.up_valid && bus.up_tuser && !full) begin
          accept  = 1'b1;
          state_d = ST_PASS;
        end
      end
      default: state_d = ST_PASS;
    endcase
  end

  assign bus.up_ready = rst;
`else
  assign accept        = 1'b1;
  assign frame_dropped = 1'b0;
  assign bus.up_ready  = rst && !full;
`endif

  // In drop mode up_ready stays high when full, so full must also gate the write.
  assign push = bus.up_valid && bus.up_ready && accept && !full;
  assign pop  = !empty && bus.down_ready;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[DEPTH_LOG2-1:0]] <= {bus.up_tuser, bus.up_tlast, bus.up_data};
  end

  assign head       = mem_q[rptr_q[DEPTH_LOG2-1:0]];
  assign fill_level = wptr_q - rptr_q;

  always_comb begin
    bus.down_valid = !empty;
    bus.down_data  = '0;
    bus.down_tlast = 1'b0;
    bus.down_tuser = 1'b0;
    if (!empty) begin
      bus.down_data  = head[D_WIDTH-1:0];
      bus.down_tlast = head[D_WIDTH];
      bus.down_tuser = head[D_WIDTH+1];
    end
  end
endmodule
